// File: rtl/bridge_pkg.sv
// Shared constants for the CPU-to-peripheral bridge: default address map,
// bridge register word offsets and error cause codes.
package bridge_pkg;

  localparam logic [31:0] DEF_DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEF_DM_LIMIT  = 32'h0000_2FFF;
  localparam logic [31:0] DEF_TC_BASE   = 32'h0000_7F00;
  localparam logic [31:0] DEF_TC_STRIDE = 32'h0000_0010;
  localparam logic [31:0] DEF_TC_SPAN   = 32'h0000_000C;
  localparam logic [31:0] DEF_BR_BASE   = 32'h0000_7F40;
  localparam logic [31:0] BR_SPAN       = 32'd16;

  // Word index within the bridge register block (address bits [3:2])
  localparam logic [1:0] OFF_IRQ_PEND = 2'd0;
  localparam logic [1:0] OFF_IRQ_MASK = 2'd1;
  localparam logic [1:0] OFF_ERR_ADDR = 2'd2;
  localparam logic [1:0] OFF_ERR_STAT = 2'd3;

  typedef enum logic {
    CAUSE_UNMAPPED   = 1'b0,
    CAUSE_PARTIAL_TC = 1'b1
  } err_cause_e;

endpackage

// File: rtl/bridge_irq_ctrl.sv
// Rising-edge interrupt latching with W1C clear and a mask register;
// drives the zero-extended masked pending vector to CP0.
module bridge_irq_ctrl #(
  parameter int SRC_W = 3,
  parameter int IRQ_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SRC_W-1:0] src_i,
  input  logic             pend_clr_i,
  input  logic             mask_we_i,
  input  logic [SRC_W-1:0] wdata_i,
  output logic [SRC_W-1:0] pend_o,
  output logic [SRC_W-1:0] mask_o,
  output logic [IRQ_W-1:0] hw_int_o
);

  logic             primed_q;
  logic [SRC_W-1:0] prev_q;
  logic [SRC_W-1:0] pend_q, pend_d;
  logic [SRC_W-1:0] mask_q, mask_d;
  logic [SRC_W-1:0] rise;

  // The first cycle after reset only seeds prev_q, so a level already high
  // at reset release is not mistaken for an edge.
  assign rise = primed_q ? (src_i & ~prev_q) : '0;

  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    if (pend_clr_i) pend_d = pend_q & ~wdata_i;
    pend_d = pend_d | rise;
    if (mask_we_i) mask_d = wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_q <= 1'b0;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '1;
    end else begin
      primed_q <= 1'b1;
      prev_q   <= src_i;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    hw_int_o              = '0;
    hw_int_o[SRC_W-1:0]   = pend_q & mask_q;
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/multi_dev_bridge.sv
// CPU data-port bridge: decodes DM / timer / bridge-register accesses,
// muxes read data, captures the first bus error and hosts the IRQ block.
module multi_dev_bridge
  import bridge_pkg::*;
#(
  parameter logic [31:0] DM_BASE   = DEF_DM_BASE,
  parameter logic [31:0] DM_LIMIT  = DEF_DM_LIMIT,
  parameter int          NUM_TC    = 2,
  parameter logic [31:0] TC_BASE   = DEF_TC_BASE,
  parameter logic [31:0] TC_STRIDE = DEF_TC_STRIDE,
  parameter logic [31:0] TC_SPAN   = DEF_TC_SPAN,
  parameter logic [31:0] BR_BASE   = DEF_BR_BASE,
  parameter int          IRQ_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_byteen,
  output logic [31:0]           cpu_rdata,
  output logic                  bus_err,
  output logic [31:0]           m_data_addr,
  output logic [31:0]           m_data_wdata,
  output logic [3:0]            m_data_byteen,
  input  logic [31:0]           m_data_rdata,
  output logic [31:0]           tc_addr,
  output logic [31:0]           tc_wdata,
  output logic [NUM_TC-1:0]     tc_we,
  input  logic [32*NUM_TC-1:0]  tc_rdata,
  input  logic [NUM_TC-1:0]     tc_irq,
  input  logic                  ext_irq,
  output logic [IRQ_W-1:0]      hw_int
);

  localparam int SRC_W = NUM_TC + 1;

  logic              sel_dm, sel_br;
  logic [NUM_TC-1:0] sel_tc;
  logic              partial_tc, unmapped, err, br_wr;
  logic [1:0]        br_off;
  logic [31:0]       br_rdata;
  logic [SRC_W-1:0]  pend, mask;

  logic        bus_err_q, bus_err_d;
  logic        err_sticky_q, err_sticky_d;
  err_cause_e  err_cause_q, err_cause_d;
  logic [31:0] err_addr_q, err_addr_d;

  // Offset-based range checks stay correct even when a base is zero.
  assign sel_dm = (cpu_addr - DM_BASE) <= (DM_LIMIT - DM_BASE);
  assign sel_br = (cpu_addr - BR_BASE) < BR_SPAN;

  for (genvar k = 0; k < NUM_TC; k++) begin : g_tc
    assign sel_tc[k] = (cpu_addr - (TC_BASE + 32'(k) * TC_STRIDE)) < TC_SPAN;
    assign tc_we[k]  = cpu_req && sel_tc[k] && (cpu_byteen == 4'hF);
  end

  assign m_data_addr   = cpu_addr;
  assign m_data_wdata  = cpu_wdata;
  assign m_data_byteen = (cpu_req && sel_dm) ? cpu_byteen : 4'h0;
  assign tc_addr       = cpu_addr;
  assign tc_wdata      = cpu_wdata;

  assign partial_tc = cpu_req && (|sel_tc) && (cpu_byteen != 4'h0) && (cpu_byteen != 4'hF);
  assign unmapped   = cpu_req && !sel_dm && !sel_br && !(|sel_tc);
  assign err        = partial_tc || unmapped;
  assign br_off     = cpu_addr[3:2];
  assign br_wr      = cpu_req && sel_br && (cpu_byteen == 4'hF);

  always_comb begin
    br_rdata = '0;
    case (br_off)
      OFF_IRQ_PEND: br_rdata = 32'(pend);
      OFF_IRQ_MASK: br_rdata = 32'(mask);
      OFF_ERR_ADDR: br_rdata = err_addr_q;
      OFF_ERR_STAT: br_rdata = {30'd0, err_cause_q, err_sticky_q};
      default:      br_rdata = '0;
    endcase
  end

  always_comb begin
    cpu_rdata = '0;
    if (sel_dm) cpu_rdata = m_data_rdata;
    if (sel_br) cpu_rdata = br_rdata;
    for (int k = 0; k < NUM_TC; k++) begin
      if (sel_tc[k]) cpu_rdata = tc_rdata[32*k +: 32];
    end
  end

  // A clear and a new error cannot both apply to one access, but the error
  // is evaluated last so it would win regardless.
  always_comb begin
    bus_err_d    = err;
    err_sticky_d = err_sticky_q;
    err_cause_d  = err_cause_q;
    err_addr_d   = err_addr_q;
    if (br_wr && br_off == OFF_ERR_STAT) begin
      err_sticky_d = 1'b0;
      err_cause_d  = CAUSE_UNMAPPED;
    end
    if (err) begin
      if (!err_sticky_q) begin
        err_addr_d  = cpu_addr;
        err_cause_d = partial_tc ? CAUSE_PARTIAL_TC : CAUSE_UNMAPPED;
      end
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cause_q  <= CAUSE_UNMAPPED;
      err_addr_q   <= '0;
    end else begin
      bus_err_q    <= bus_err_d;
      err_sticky_q <= err_sticky_d;
      err_cause_q  <= err_cause_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign bus_err = bus_err_q;

  bridge_irq_ctrl #(
    .SRC_W (SRC_W),
    .IRQ_W (IRQ_W)
  ) u_irq (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_i      ({ext_irq, tc_irq}),
    .pend_clr_i (br_wr && br_off == OFF_IRQ_PEND),
    .mask_we_i  (br_wr && br_off == OFF_IRQ_MASK),
    .wdata_i    (cpu_wdata[SRC_W-1:0]),
    .pend_o     (pend),
    .mask_o     (mask),
    .hw_int_o   (hw_int)
  );

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Self-checking bench for multi_dev_bridge: directed scenarios followed by
// randomized accesses, all compared against a behavioural address-map model.
module tb_multi_dev_bridge;

  localparam int          NUM_TC = 2;
  localparam int          IRQ_W  = 6;
  localparam logic [31:0] TCB    = 32'h0000_7F00;
  localparam logic [31:0] BRB    = 32'h0000_7F40;
  localparam int          RG_DM  = 100;
  localparam int          RG_BR  = 200;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cpu_req;
  logic [31:0]          cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]           cpu_byteen;
  logic                 bus_err;
  logic [31:0]          m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]           m_data_byteen;
  logic [31:0]          tc_addr, tc_wdata;
  logic [NUM_TC-1:0]    tc_we, tc_irq;
  logic [32*NUM_TC-1:0] tc_rdata;
  logic                 ext_irq;
  logic [IRQ_W-1:0]     hw_int;

  int total = 0;
  int bad   = 0;

  // Reference model state, expressed in terms of the programmer-visible registers
  logic [2:0]  mPend, mMask, mPrev;
  bit          mPrimed, mSticky, mCause, mBusErr;
  logic [31:0] mErrAddr;

  always #5 clk = ~clk;

  multi_dev_bridge dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_byteen    (cpu_byteen),
    .cpu_rdata     (cpu_rdata),
    .bus_err       (bus_err),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .tc_addr       (tc_addr),
    .tc_wdata      (tc_wdata),
    .tc_we         (tc_we),
    .tc_rdata      (tc_rdata),
    .tc_irq        (tc_irq),
    .ext_irq       (ext_irq),
    .hw_int        (hw_int)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Region lookup straight from the documented address map
  function automatic int regionOf(input logic [31:0] a);
    if (a <= 32'h0000_2FFF) return RG_DM;
    for (int k = 0; k < NUM_TC; k++) begin
      if (a >= TCB + 32'(k * 16) && a < TCB + 32'(k * 16 + 12)) return k;
    end
    if (a >= BRB && a <= BRB + 32'd15) return RG_BR;
    return -1;
  endfunction

  task automatic modelReset();
    mPend    = '0;
    mMask    = 3'b111;
    mPrev    = '0;
    mPrimed  = 0;
    mSticky  = 0;
    mCause   = 0;
    mBusErr  = 0;
    mErrAddr = '0;
  endtask

  // Drives one access for one clock, checks the same-cycle outputs at the
  // falling edge, then advances the model to the next rising edge.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [1:0] irqIn, input logic extIn);
    int          region;
    logic [31:0] off, expRd;
    logic [3:0]  expBe;
    logic [1:0]  expWe;
    logic [2:0]  src, rise, nextPend;
    bit          isErr, wordWr;

    cpu_req      = req;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    cpu_byteen   = be;
    tc_irq       = irqIn;
    ext_irq      = extIn;
    m_data_rdata = $urandom;
    tc_rdata     = {$urandom, $urandom};
    @(negedge clk);

    region = regionOf(addr);
    off    = (addr - BRB) >> 2;
    expRd  = '0;
    if (region == RG_DM) expRd = m_data_rdata;
    else if (region == RG_BR) begin
      case (off)
        0: expRd = {29'd0, mPend};
        1: expRd = {29'd0, mMask};
        2: expRd = mErrAddr;
        default: expRd = {30'd0, mCause, mSticky};
      endcase
    end else if (region >= 0) expRd = tc_rdata[32*region +: 32];

    expBe = (req && region == RG_DM) ? be : 4'h0;
    expWe = '0;
    for (int k = 0; k < NUM_TC; k++) expWe[k] = req && region == k && be == 4'hF;

    checkOutput("rdata", cpu_rdata, expRd);
    checkOutput("dm_byteen", {28'd0, m_data_byteen}, {28'd0, expBe});
    checkOutput("tc_we", {30'd0, tc_we}, {30'd0, expWe});
    checkOutput("hw_int", {26'd0, hw_int}, {29'd0, mPend & mMask});
    checkOutput("bus_err", {31'd0, bus_err}, {31'd0, mBusErr});
    checkOutput("dm_addr", m_data_addr, addr);
    checkOutput("tc_wdata", tc_wdata, wdata);

    src      = {extIn, irqIn};
    rise     = mPrimed ? (src & ~mPrev) : 3'b000;
    isErr    = req && (region < 0 || (region < NUM_TC && be != 4'h0 && be != 4'hF));
    wordWr   = req && region == RG_BR && be == 4'hF;
    nextPend = mPend;
    if (wordWr && off == 0) nextPend = nextPend & ~wdata[2:0];
    nextPend = nextPend | rise;
    if (wordWr && off == 1) mMask = wdata[2:0];
    if (wordWr && off == 3) begin
      mSticky = 0;
      mCause  = 0;
    end
    if (isErr) begin
      if (!mSticky) begin
        mErrAddr = addr;
        mCause   = (region >= 0);
      end
      mSticky = 1;
    end
    mBusErr = isErr;
    mPend   = nextPend;
    mPrev   = src;
    mPrimed = 1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted in the middle of a cycle; state must clear at once
  task automatic resetMid();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_hw_int", {26'd0, hw_int}, 32'd0);
    checkOutput("rst_bus_err", {31'd0, bus_err}, 32'd0);
    cpu_req    = 1'b1;
    cpu_byteen = 4'h0;
    cpu_addr   = BRB + 32'hC;
    #1 checkOutput("rst_err_stat", cpu_rdata, 32'd0);
    cpu_addr = BRB;
    #1 checkOutput("rst_pend", cpu_rdata, 32'd0);
    cpu_addr = BRB + 32'h4;
    #1 checkOutput("rst_mask", cpu_rdata, 32'h7);
    modelReset();
    // Level already high while reset releases must not count as an edge
    tc_irq = 2'b10;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic [1:0]  irq;
    logic        ext;

    reset_n      = 1'b0;
    cpu_req      = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    cpu_byteen   = '0;
    m_data_rdata = '0;
    tc_rdata     = '0;
    tc_irq       = '0;
    ext_irq      = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state and DM boundary
    applyStimulus(1, BRB + 32'h4, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, 32'h0000_2FFC, 32'h1234_5678, 4'hF, 2'b00, 0);
    applyStimulus(1, 32'h0000_3000, 32'h1234_5678, 4'hF, 2'b00, 0);
    applyStimulus(1, BRB + 32'h8, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, BRB + 32'hC, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, BRB + 32'hC, 0, 4'hF, 2'b00, 0);

    // Timer slots, partial timer write, gap and sticky error address
    applyStimulus(1, TCB + 32'h14, 32'hCAFE_0001, 4'hF, 2'b00, 0);
    applyStimulus(1, TCB + 32'h14, 32'hCAFE_0002, 4'h3, 2'b00, 0);
    applyStimulus(1, BRB + 32'hC, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, TCB + 32'h0C, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, BRB + 32'h8, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, TCB + 32'h08, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, BRB + 32'hC, 32'hFFFF_FFFF, 4'h5, 2'b00, 0);
    applyStimulus(1, BRB + 32'hC, 0, 4'h0, 2'b00, 0);

    // IRQ edge, W1C while level held, edge racing a clear, mask
    applyStimulus(1, BRB, 0, 4'h0, 2'b01, 0);
    applyStimulus(1, BRB, 0, 4'h0, 2'b01, 0);
    applyStimulus(1, BRB, 32'h1, 4'hF, 2'b01, 0);
    applyStimulus(1, BRB, 0, 4'h0, 2'b01, 0);
    applyStimulus(1, BRB, 0, 4'h0, 2'b00, 0);
    applyStimulus(1, BRB, 32'h1, 4'hF, 2'b01, 0);
    applyStimulus(1, BRB, 0, 4'h0, 2'b01, 1);
    applyStimulus(1, BRB + 32'h4, 32'h0, 4'hF, 2'b01, 1);
    applyStimulus(1, BRB, 0, 4'h0, 2'b01, 1);
    applyStimulus(1, BRB + 32'h4, 32'hFFFF_FFFF, 4'hF, 2'b01, 1);
    applyStimulus(1, BRB + 32'h4, 0, 4'h0, 2'b01, 1);

    // Reset in the middle of an error pulse with interrupts pending
    applyStimulus(1, 32'h0000_3000, 0, 4'hF, 2'b01, 1);
    resetMid();
    applyStimulus(1, BRB, 0, 4'h0, 2'b10, 0);
    applyStimulus(1, BRB, 0, 4'h0, 2'b10, 0);
    applyStimulus(0, 32'h0000_3000, 0, 4'hF, 2'b00, 0);
    applyStimulus(1, BRB, 0, 4'h0, 2'b10, 0);

    // Randomized accesses across every region and its edges
    irq = 2'b00;
    ext = 1'b0;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = $urandom_range(32'h2FF8, 32'h3007);
        2: a = $urandom_range(32'h7EF8, 32'h7F2F);
        3: a = BRB + {$urandom_range(0, 3), 2'b00};
        4: a = BRB + {$urandom_range(0, 3), 2'b00};
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: be = 4'h0;
        1, 2: be = 4'hF;
        default: be = 4'($urandom);
      endcase
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) irq[0] = ~irq[0];
      if ($urandom_range(0, 3) == 0) irq[1] = ~irq[1];
      if ($urandom_range(0, 5) == 0) ext = ~ext;
      applyStimulus(1'($urandom_range(0, 7) != 0), a, wd, be, irq, ext);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
